// File: rtl/corerfd_lock_pkg.sv
// Shared constants for the CORERFD lock qualifier: FSM encoding and loss counter limits.
package corerfd_lock_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_QUAL   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam int         LOSS_CNT_W   = 8;
    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_QUAL   = ST_QUAL,
        S_LOCKED = ST_LOCKED
    } lock_state_t;

endpackage

// File: rtl/corerfd_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Async active-high reset clears both stages.
module corerfd_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/corerfd_lock_qual.sv
// Lock qualifier: filters a PLL/DLL lock flag against a tick time base.
// Optional saturating loss counter enabled by CORERFD_LOCK_LOSS_CNT_EN.
module corerfd_lock_qual
    import corerfd_lock_pkg::*;
#(
    parameter int QUAL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  lock_raw,
    input  logic                  enable,
    input  logic [QUAL_W-1:0]     qual_cnt,
    input  logic                  clr_sticky,
    output logic                  locked,
    output logic                  lock_lost_pulse,
    output logic                  lock_lost_sticky,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [QUAL_W-1:0] r_cnt;
    logic [QUAL_W-1:0] w_cnt_nxt;
    logic [QUAL_W-1:0] r_qual;
    logic [QUAL_W-1:0] w_qual_nxt;
    logic [QUAL_W:0]   w_cnt_inc;
    logic              w_lock_s;
    logic              w_loss;
    logic              r_locked;
    logic              r_pulse;
    logic              r_sticky;

    corerfd_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock_raw),
        .q   (w_lock_s)
    );

    // Extra bit keeps the terminal compare exact at the top of the range
    assign w_cnt_inc = {1'b0, r_cnt} + {{QUAL_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_qual_nxt  = r_qual;
        w_loss      = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_lock_s) begin
                        w_state_nxt = S_QUAL;
                        w_cnt_nxt   = '0;
                        w_qual_nxt  = (qual_cnt == '0)
                                    ? {{(QUAL_W-1){1'b0}}, 1'b1}
                                    : qual_cnt;
                    end
                end
                S_QUAL: begin
                    if (!w_lock_s) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (tick) begin
                        w_cnt_nxt = w_cnt_inc[QUAL_W-1:0];
                        if (w_cnt_inc == {1'b0, r_qual}) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!w_lock_s) begin
                        w_state_nxt = S_WAIT;
                        w_loss      = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_qual   <= '0;
            r_locked <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_qual   <= w_qual_nxt;
            r_locked <= (w_state_nxt == S_LOCKED);
            r_pulse  <= w_loss;
        end
    end

    // A loss in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_loss) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

`ifdef CORERFD_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (clr_sticky) begin
            r_loss_cnt <= w_loss ? LOSS_CNT_W'(1) : '0;
        end else if (w_loss && (r_loss_cnt != LOSS_CNT_MAX)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = '0;
`endif

    assign locked           = r_locked;
    assign lock_lost_pulse  = r_pulse;
    assign lock_lost_sticky = r_sticky;
    assign state            = r_state;

endmodule
